// File: rtl/sig_press_decode.sv
// Press classifier: turns a deglitched, clk-synchronous level into SHORT/LONG/DOUBLE events behind a one-entry valid/ready buffer.
// Optional auto-repeat while held is enabled by defining SIG_PRESS_REPEAT_EN.
module sig_press_decode #(
    parameter logic ACT_LVL     = 1'b0,
    parameter int   CNT_W       = 16,
    parameter int   LONG_CYC    = 1000,
    parameter int   DBL_GAP_CYC = 300,
    parameter int   REPEAT_CYC  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_f,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [1:0]       evt_code,
    output logic [CNT_W-1:0] evt_width,
    output logic             evt_ovf
);

    if (CNT_W < 2 || LONG_CYC < 2 || DBL_GAP_CYC < 2 || REPEAT_CYC < 1 ||
        longint'(LONG_CYC) > ((longint'(1) << CNT_W) - 1) ||
        longint'(DBL_GAP_CYC) > ((longint'(1) << CNT_W) - 1)) begin : g_param_chk
        $error("sig_press_decode: threshold parameters out of range for CNT_W");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_WAIT_DBL,
        S_PRESS2,
        S_HOLD
    } state_e;

    localparam logic [1:0]       CODE_REPEAT = 2'b00;
    localparam logic [1:0]       CODE_SHORT  = 2'b01;
    localparam logic [1:0]       CODE_LONG   = 2'b10;
    localparam logic [1:0]       CODE_DOUBLE = 2'b11;
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LIM    = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] GAP_LIM     = CNT_W'(DBL_GAP_CYC);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    state_e           state_q, state_d;
    logic             act_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] wid_q, wid_d;
    logic             valid_q, valid_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             ovf_q, ovf_d;

    logic             act, press;
    logic [CNT_W-1:0] cnt_inc, gap_inc;
    logic             new_evt;
    logic [1:0]       new_code;
    logic [CNT_W-1:0] new_width;

    assign act     = (host_f == ACT_LVL);
    assign press   = act & ~act_q;
    assign cnt_inc = sat_inc(cnt_q);
    assign gap_inc = sat_inc(gap_q);

`ifdef SIG_PRESS_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_CYC);
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] rep_inc;
    assign rep_inc = sat_inc(rep_q);
`endif

    // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        wid_d     = wid_q;
        new_evt   = 1'b0;
        new_code  = CODE_SHORT;
        new_width = '0;
`ifdef SIG_PRESS_REPEAT_EN
        // Anything outside HOLD keeps the repeat counter clear, so it starts from zero on entry.
        rep_d     = (state_q == S_HOLD) ? rep_q : '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_PRESS;
                    cnt_d   = ONE;
                end
            end
            S_PRESS: begin
                if (act) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LONG_LIM) begin
                        new_evt   = 1'b1;
                        new_code  = CODE_LONG;
                        new_width = LONG_LIM;
                        state_d   = S_HOLD;
                    end
                end else begin
                    state_d = S_WAIT_DBL;
                    wid_d   = cnt_q;
                    gap_d   = ONE;
                end
            end
            S_WAIT_DBL: begin
                if (press) begin
                    state_d = S_PRESS2;
                    cnt_d   = ONE;
                end else begin
                    gap_d = gap_inc;
                    if (gap_inc == GAP_LIM) begin
                        new_evt   = 1'b1;
                        new_code  = CODE_SHORT;
                        new_width = wid_q;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_PRESS2: begin
                if (act) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LONG_LIM) begin
                        new_evt   = 1'b1;
                        new_code  = CODE_DOUBLE;
                        new_width = LONG_LIM;
                        state_d   = S_HOLD;
                    end
                end else begin
                    new_evt   = 1'b1;
                    new_code  = CODE_DOUBLE;
                    new_width = cnt_q;
                    state_d   = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!act) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
`ifdef SIG_PRESS_REPEAT_EN
                    rep_d = rep_inc;
                    if (rep_inc == REP_LIM) begin
                        new_evt   = 1'b1;
                        new_code  = CODE_REPEAT;
                        new_width = cnt_inc;
                        rep_d     = '0;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The FSM never waits on the buffer: an event arriving while one is still held is dropped and flagged.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        width_d = width_q;
        ovf_d   = 1'b0;
        if (new_evt) begin
            if (!valid_q || evt_ready) begin
                valid_d = 1'b1;
                code_d  = new_code;
                width_d = new_width;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && evt_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
            wid_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 2'b00;
            width_q <= '0;
            ovf_q   <= 1'b0;
`ifdef SIG_PRESS_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            act_q   <= act;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            wid_q   <= wid_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            width_q <= width_d;
            ovf_q   <= ovf_d;
`ifdef SIG_PRESS_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign evt_valid = valid_q;
    assign evt_code  = code_q;
    assign evt_width = width_q;
    assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_sig_press_decode.sv
// Bench for sig_press_decode: directed vector table, overflow/reset sequences and a random run against a run-length reference model.
module tb_sig_press_decode;

    localparam logic ACT  = 1'b0;
    localparam int   CW   = 16;
    localparam int   LONG = 8;
    localparam int   GAP  = 4;
    localparam int   REP  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_f;
    logic          evt_ready;
    logic          evt_valid;
    logic [1:0]    evt_code;
    logic [CW-1:0] evt_width;
    logic          evt_ovf;

    sig_press_decode #(
        .ACT_LVL    (ACT),
        .CNT_W      (CW),
        .LONG_CYC   (LONG),
        .DBL_GAP_CYC(GAP),
        .REPEAT_CYC (REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .host_f   (host_f),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_width(evt_width),
        .evt_ovf  (evt_ovf)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: run lengths of active/inactive samples plus a one-entry buffer.
    int            m_run;
    int            m_pend;
    int            m_gap;
    bit            m_held;
    bit            m_second;
    logic          exp_valid;
    logic          exp_ovf;
    logic [1:0]    exp_code;
    logic [CW-1:0] exp_width;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_out();
        return {12'd0, evt_valid, evt_ovf, evt_code, evt_width};
    endfunction

    function automatic logic [31:0] exp_out();
        return {12'd0, exp_valid, exp_ovf, exp_code, exp_width};
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_gap = 0; m_held = 0; m_second = 0;
        exp_valid = 0; exp_ovf = 0; exp_code = 2'b00; exp_width = '0;
    endtask

    task automatic model_sample(input bit a, output bit e, output logic [1:0] c, output int w);
        e = 0; c = 2'b00; w = 0;
        if (a) begin
            if (m_run == 0) begin
                m_second = (m_pend > 0);
                m_pend   = 0;
                m_held   = 0;
            end
            m_run++;
            if (!m_held && m_run == LONG) begin
                e = 1; c = m_second ? 2'b11 : 2'b10; w = LONG; m_held = 1;
            end
`ifdef SIG_PRESS_REPEAT_EN
            else if (m_held && ((m_run - LONG) % REP == 0)) begin
                e = 1; c = 2'b00; w = (m_run > 65535) ? 65535 : m_run;
            end
`endif
        end else begin
            if (m_run > 0) begin
                if (!m_held) begin
                    if (m_second) begin
                        e = 1; c = 2'b11; w = m_run;
                    end else begin
                        m_pend = m_run; m_gap = 1;
                    end
                end
                m_run = 0; m_held = 0; m_second = 0;
            end else if (m_pend > 0) begin
                m_gap++;
                if (m_gap == GAP) begin
                    e = 1; c = 2'b01; w = m_pend; m_pend = 0;
                end
            end
        end
    endtask

    task automatic step(input logic h, input logic r);
        bit         e;
        logic [1:0] c;
        int         w;
        @(negedge clk);
        host_f    = h;
        evt_ready = r;
        @(posedge clk);
        model_sample(h == ACT, e, c, w);
        exp_ovf = 1'b0;
        if (e) begin
            if (!exp_valid || r) begin
                exp_valid = 1'b1; exp_code = c; exp_width = CW'(w);
            end else begin
                exp_ovf = 1'b1;
            end
        end else if (exp_valid && r) begin
            exp_valid = 1'b0;
        end
        #1;
        check("step", dut_out(), exp_out());
    endtask

    task automatic apply_reset(input bit toggle, input int cycles);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async", dut_out(), 32'd0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            host_f = toggle ? ~host_f : 1'b1;
            @(posedge clk);
            #1;
            check("in_rst", dut_out(), 32'd0);
        end
        @(negedge clk);
        host_f = 1'b1;
        rst    = 1'b0;
    endtask

    typedef struct {
        string         name;
        logic [31:0]   pat;
        int            len;
        int            n_evt;
        int            first_idx;
        logic [1:0]    code;
        logic [CW-1:0] width;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int         n;
        int         first;
        logic [1:0] last_c;
        logic [CW-1:0] last_w;
        int         ovf_cnt;
        logic [31:0] pat;

        tbl[0] = '{"short",     32'h0000_01F8,  9, 1, 6, 2'b01, 16'd3};
        tbl[1] = '{"long",      32'h0000_3C00, 14, 1, 7, 2'b10, 16'd8};
        tbl[2] = '{"double",    32'h0000_3F8C, 14, 1, 7, 2'b11, 16'd3};
        tbl[3] = '{"two_short", 32'h0000_3E3C, 14, 2, 5, 2'b01, 16'd3};
        tbl[4] = '{"dbl_long",  32'h0000_3804, 14, 1, 10, 2'b11, 16'd8};
`ifdef SIG_PRESS_REPEAT_EN
        tbl[5] = '{"long_rep",  32'h0003_C000, 18, 3, 7, 2'b00, 16'd14};
`else
        tbl[5] = '{"long_rep",  32'h0003_C000, 18, 1, 7, 2'b10, 16'd8};
`endif

        rst = 1'b0; host_f = 1'b1; evt_ready = 1'b1;
        model_reset();
        #2;

        // Reset with host_f idle, then with host_f toggling; nothing may appear after release.
        apply_reset(1'b0, 3);
        apply_reset(1'b1, 4);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);

        foreach (tbl[k]) begin
            for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
            n = 0; first = -1; last_c = 2'b00; last_w = '0;
            pat = tbl[k].pat;
            for (int i = 0; i < tbl[k].len; i++) begin
                step(pat[i], 1'b1);
                if (evt_valid) begin
                    if (n == 0) first = i;
                    n++;
                    last_c = evt_code;
                    last_w = evt_width;
                end
            end
            check({tbl[k].name, "_count"}, n, tbl[k].n_evt);
            check({tbl[k].name, "_first"}, first, tbl[k].first_idx);
            check({tbl[k].name, "_code"}, {30'd0, last_c}, {30'd0, tbl[k].code});
            check({tbl[k].name, "_width"}, {16'd0, last_w}, {16'd0, tbl[k].width});
        end

        // Consumer stalled: the first SHORT is held, the second is dropped with a single ovf pulse.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        ovf_cnt = 0;
        pat = 32'h0000_003C;
        for (int i = 0; i < 6; i++) begin
            step(pat[i], 1'b0);
            if (evt_ovf) ovf_cnt++;
        end
        pat = 32'h0000_0078;
        for (int i = 0; i < 7; i++) begin
            step(pat[i], 1'b0);
            if (evt_ovf) ovf_cnt++;
        end
        step(1'b1, 1'b0);
        if (evt_ovf) ovf_cnt++;
        check("ovf_pulses", ovf_cnt, 1);
        check("held_evt", {13'd0, evt_valid, evt_code, evt_width}, {13'd0, 1'b1, 2'b01, 16'd2});
        step(1'b1, 1'b1);
        check("accept_clears", {31'd0, evt_valid}, 32'd0);

        // Reset in the middle of a press: everything returns to reset values.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        apply_reset(1'b0, 2);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);

        // Random press/gap lengths with a randomly stalling consumer.
        for (int k = 0; k < 200; k++) begin
            int a_len;
            int i_len;
            a_len = $urandom_range(1, 12);
            i_len = $urandom_range(1, 7);
            for (int i = 0; i < a_len; i++) step(1'b0, $urandom_range(0, 3) != 0);
            for (int i = 0; i < i_len; i++) step(1'b1, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) apply_reset(1'b1, 2);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
